// File: rtl/rc5_req_scheduler.sv
// Shares one rc5_core between two requesters: round-robin grant, key-cache
// reuse, block issue, result return and a watchdog that aborts a stalled core.
module rc5_req_scheduler #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_key,
  input  logic         req0_flag,
  input  logic [63:0]  req0_din,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_key,
  input  logic         req1_flag,
  input  logic [63:0]  req1_din,
  output logic         rsp0_valid,
  output logic [63:0]  rsp0_dout,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  output logic [63:0]  rsp1_dout,
  output logic         rsp1_err,
  output logic [127:0] core_key,
  output logic         core_key_en,
  input  logic         core_key_ok,
  output logic         core_flag,
  output logic [63:0]  core_din,
  output logic         core_din_en,
  input  logic [63:0]  core_dout,
  input  logic         core_dout_en,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_LOAD,
    S_KEY_WAIT,
    S_ISSUE,
    S_DATA_WAIT,
    S_RESPOND
  } state_t;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               gnt_q, gnt_d;
  logic [127:0]       key_q, key_d;
  logic               flag_q, flag_d;
  logic [63:0]        din_q, din_d;
  logic [127:0]       cached_key_q, cached_key_d;
  logic               key_cached_q, key_cached_d;
  logic [TW-1:0]      wd_q, wd_d;
  logic [63:0]        res_q, res_d;
  logic               err_q, err_d;
  logic [1:0]         ready_q, ready_d;
  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_err_q, rsp_err_d;
  logic [1:0][63:0]   rsp_dout_q, rsp_dout_d;
  logic [127:0]       core_key_q, core_key_d;
  logic               core_key_en_q, core_key_en_d;
  logic               core_flag_q, core_flag_d;
  logic [63:0]        core_din_q, core_din_d;
  logic               core_din_en_q, core_din_en_d;

  logic               any_req;
  logic               sel_port;
  logic [127:0]       sel_key;
  logic               sel_flag;
  logic [63:0]        sel_din;
  logic               cache_hit;
  logic               wd_expired;

  // On a tie the port that was not served last wins.
  assign any_req   = req0_valid | req1_valid;
  assign sel_port  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign sel_key   = sel_port ? req1_key  : req0_key;
  assign sel_flag  = sel_port ? req1_flag : req0_flag;
  assign sel_din   = sel_port ? req1_din  : req0_din;
  assign cache_hit = key_cached_q && (cached_key_q == sel_key);
  assign wd_expired = (wd_q == WD_LAST);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gnt_d         = gnt_q;
    key_d         = key_q;
    flag_d        = flag_q;
    din_d         = din_q;
    cached_key_d  = cached_key_q;
    key_cached_d  = key_cached_q;
    wd_d          = wd_q;
    res_d         = res_q;
    err_d         = err_q;
    ready_d       = 2'b00;
    rsp_valid_d   = 2'b00;
    rsp_err_d     = rsp_err_q;
    rsp_dout_d    = rsp_dout_q;
    core_key_d    = core_key_q;
    core_key_en_d = 1'b0;
    core_flag_d   = core_flag_q;
    core_din_d    = core_din_q;
    core_din_en_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d             = sel_port;
          last_grant_d      = sel_port;
          ready_d[sel_port] = 1'b1;
          key_d             = sel_key;
          flag_d            = sel_flag;
          din_d             = sel_din;
          err_d             = 1'b0;
          state_d           = cache_hit ? S_ISSUE : S_KEY_LOAD;
        end
      end
      S_KEY_LOAD: begin
        core_key_d    = key_q;
        core_key_en_d = 1'b1;
        key_cached_d  = 1'b0;
        wd_d          = '0;
        state_d       = S_KEY_WAIT;
      end
      S_KEY_WAIT: begin
        // key_ok seen alongside our own load strobe belongs to the previous key.
        if (core_key_ok && !core_key_en_q) begin
          cached_key_d = key_q;
          key_cached_d = 1'b1;
          state_d      = S_ISSUE;
        end else if (wd_expired) begin
          err_d        = 1'b1;
          res_d        = '0;
          key_cached_d = 1'b0;
          state_d      = S_RESPOND;
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end
      S_ISSUE: begin
        core_din_d    = din_q;
        core_flag_d   = flag_q;
        core_din_en_d = 1'b1;
        wd_d          = '0;
        state_d       = S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        // Result arriving on the expiry cycle still counts as a good result.
        if (core_dout_en) begin
          res_d   = core_dout;
          state_d = S_RESPOND;
        end else if (wd_expired) begin
          err_d        = 1'b1;
          res_d        = '0;
          key_cached_d = 1'b0;
          state_d      = S_RESPOND;
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end
      S_RESPOND: begin
        rsp_valid_d[gnt_q] = 1'b1;
        rsp_dout_d[gnt_q]  = res_q;
        rsp_err_d[gnt_q]   = err_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      gnt_q         <= 1'b0;
      key_q         <= '0;
      flag_q        <= 1'b0;
      din_q         <= '0;
      cached_key_q  <= '0;
      key_cached_q  <= 1'b0;
      wd_q          <= '0;
      res_q         <= '0;
      err_q         <= 1'b0;
      ready_q       <= 2'b00;
      rsp_valid_q   <= 2'b00;
      rsp_err_q     <= 2'b00;
      rsp_dout_q    <= '0;
      core_key_q    <= '0;
      core_key_en_q <= 1'b0;
      core_flag_q   <= 1'b0;
      core_din_q    <= '0;
      core_din_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gnt_q         <= gnt_d;
      key_q         <= key_d;
      flag_q        <= flag_d;
      din_q         <= din_d;
      cached_key_q  <= cached_key_d;
      key_cached_q  <= key_cached_d;
      wd_q          <= wd_d;
      res_q         <= res_d;
      err_q         <= err_d;
      ready_q       <= ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_dout_q    <= rsp_dout_d;
      core_key_q    <= core_key_d;
      core_key_en_q <= core_key_en_d;
      core_flag_q   <= core_flag_d;
      core_din_q    <= core_din_d;
      core_din_en_q <= core_din_en_d;
    end
  end

  assign req0_ready  = ready_q[0];
  assign req1_ready  = ready_q[1];
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_dout   = rsp_dout_q[0];
  assign rsp1_dout   = rsp_dout_q[1];
  assign rsp0_err    = rsp_err_q[0];
  assign rsp1_err    = rsp_err_q[1];
  assign core_key    = core_key_q;
  assign core_key_en = core_key_en_q;
  assign core_flag   = core_flag_q;
  assign core_din    = core_din_q;
  assign core_din_en = core_din_en_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_rc5_req_scheduler.sv
// Directed + randomized bench for rc5_req_scheduler with a behavioural core
// stand-in and a transaction-level reference model of grant, cache and timing.
module tb_rc5_req_scheduler;

  localparam int TIMEOUT = 16;
  localparam int TW      = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   v = 2'b00;
  logic [127:0] key_a [2];
  logic         flag_a [2];
  logic [63:0]  din_a [2];

  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [63:0]  rsp0_dout, rsp1_dout;
  logic [127:0] core_key;
  logic         core_key_en, core_flag, core_din_en, busy;
  logic [63:0]  core_din;
  logic         core_key_ok = 1'b0;
  logic         core_dout_en = 1'b0;
  logic [63:0]  core_dout = '0;

  rc5_req_scheduler #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_key(key_a[0]),
    .req0_flag(flag_a[0]), .req0_din(din_a[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_key(key_a[1]),
    .req1_flag(flag_a[1]), .req1_din(din_a[1]),
    .rsp0_valid(rsp0_valid), .rsp0_dout(rsp0_dout), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_dout(rsp1_dout), .rsp1_err(rsp1_err),
    .core_key(core_key), .core_key_en(core_key_en), .core_key_ok(core_key_ok),
    .core_flag(core_flag), .core_din(core_din), .core_din_en(core_din_en),
    .core_dout(core_dout), .core_dout_en(core_dout_en), .busy(busy)
  );

  // Stand-in cipher: any fixed keyed function exposes a stale or wrong key.
  function automatic logic [63:0] fcore(input logic [127:0] k, input logic f,
                                        input logic [63:0] d);
    return f ? ((d ^ k[63:0]) + k[127:64]) : ((d - k[127:64]) ^ k[63:0] ^ 64'h5A5A_A5A5_0F0F_F0F0);
  endfunction

  int key_lat = 1;
  int dat_lat = 1;
  bit silent  = 1'b0;
  int kcnt = 0, dcnt = 0, key_loads = 0, cyc = 0;
  logic [127:0] ck = '0;
  logic [63:0]  cd = '0;
  logic         cf = 1'b0;

  // Core model, evaluated mid-cycle so its outputs are stable at the next edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    core_dout_en = 1'b0;
    if (kcnt > 0) begin
      kcnt = kcnt - 1;
      if (kcnt == 0) core_key_ok = 1'b1;
    end
    if (dcnt > 0) begin
      dcnt = dcnt - 1;
      if (dcnt == 0) begin
        core_dout_en = 1'b1;
        core_dout    = fcore(ck, cf, cd);
      end
    end
    if (core_key_en) begin
      key_loads   = key_loads + 1;
      ck          = core_key;
      core_key_ok = 1'b0;
      kcnt        = key_lat;
    end
    if (core_din_en && !silent) begin
      cd   = core_din;
      cf   = core_flag;
      dcnt = dat_lat;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit           m_last = 1'b1;
  bit           m_cached = 1'b0;
  logic [127:0] m_ckey = '0;
  logic [127:0] kpool [3];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ctrl"}, 128'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err,
                              rsp1_err, core_key_en, core_din_en, core_flag, busy}), 128'(0));
    chk({tag, ".data"}, 128'(rsp0_dout | rsp1_dout | core_din), 128'(0));
    chk({tag, ".key"}, core_key, 128'(0));
  endtask

  // One request from grant to response, checked against the reference rules.
  task automatic txn(input logic [1:0] want, input bit rehold, input string tag);
    logic [1:0] rdy, vs;
    logic [63:0] exp_d, obs_d;
    logic obs_e;
    bit got, reload, kerr, derr, exp_err;
    int p, exp_p, t0, kl0, lat, e;
    v = v | want;
    got = 1'b0; rdy = '0; vs = '0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (req0_ready || req1_ready) begin
        got = 1'b1; rdy = {req1_ready, req0_ready}; vs = v;
        break;
      end
    end
    chk({tag, ".ready_seen"}, 128'(got), 128'(1));
    if (!got) begin
      v = 2'b00;
      return;
    end
    exp_p = (vs == 2'b11) ? (m_last ? 0 : 1) : (vs[1] ? 1 : 0);
    chk({tag, ".ready_port"}, 128'(rdy), 128'((exp_p == 1) ? 2'b10 : 2'b01));
    p   = rdy[1] ? 1 : 0;
    t0  = cyc;
    kl0 = key_loads;
    reload  = !(m_cached && (m_ckey == key_a[p]));
    kerr    = reload && (key_lat >= TIMEOUT);
    derr    = !kerr && (silent || (dat_lat >= TIMEOUT));
    exp_err = kerr || derr;
    e = reload ? key_lat + 3 : 1;
    if (kerr)      lat = TIMEOUT + 2;
    else if (derr) lat = e + TIMEOUT + 1;
    else           lat = e + dat_lat + 2;
    exp_d = exp_err ? 64'h0 : fcore(key_a[p], flag_a[p], din_a[p]);
    v[p]   = 1'b0;
    m_last = (p == 1);
    got = 1'b0;
    for (int i = 0; i < 3 * TIMEOUT + 64; i++) begin
      step();
      if (rsp0_valid || rsp1_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, ".rsp_seen"}, 128'(got), 128'(1));
    obs_d = (p == 1) ? rsp1_dout : rsp0_dout;
    obs_e = (p == 1) ? rsp1_err : rsp0_err;
    chk({tag, ".rsp_port"}, 128'({rsp1_valid, rsp0_valid}), 128'((p == 1) ? 2'b10 : 2'b01));
    chk({tag, ".dout"}, 128'(obs_d), 128'(exp_d));
    chk({tag, ".err"}, 128'(obs_e), 128'(exp_err));
    chk({tag, ".latency"}, 128'(cyc - t0), 128'(lat));
    chk({tag, ".key_loads"}, 128'(key_loads - kl0), 128'(reload));
    $display("[TB] %s port=%0d flag=%0d din=%h dout=%h err=%0d lat=%0d reload=%0d",
             tag, p, flag_a[p], din_a[p], obs_d, obs_e, cyc - t0, reload);
    m_cached = !exp_err;
    m_ckey   = key_a[p];
    if (rehold) begin
      din_a[p]  = {$urandom, $urandom};
      flag_a[p] = 1'($urandom_range(0, 1));
      v[p]      = 1'b1;
    end
  endtask

  initial begin
    int rsp_cnt;
    bit seen;
    kpool[0] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    kpool[1] = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;
    kpool[2] = 128'h1357_9BDF_2468_ACE0_0F1E_2D3C_4B5A_6978;
    for (int i = 0; i < 2; i++) begin
      key_a[i] = '0; flag_a[i] = 1'b0; din_a[i] = '0;
    end

    repeat (3) step();
    check_zero("reset");
    rst = 1'b1;
    step();

    key_a[0] = kpool[0]; din_a[0] = 64'h0123456789ABCDEF; flag_a[0] = 1'b1;
    txn(2'b01, 1'b0, "t1_first");
    din_a[0] = {$urandom, $urandom}; flag_a[0] = 1'b0;
    txn(2'b01, 1'b0, "t2_hit");

    // Fresh reset so the tie-break history and cache start clean.
    rst = 1'b0; step(); rst = 1'b1; step();
    m_last = 1'b1; m_cached = 1'b0;
    key_a[0] = kpool[0]; key_a[1] = kpool[1];
    din_a[0] = {$urandom, $urandom}; din_a[1] = {$urandom, $urandom};
    flag_a[0] = 1'b1; flag_a[1] = 1'b0;
    v = 2'b11;
    for (int i = 0; i < 4; i++) txn(2'b11, (i < 2), $sformatf("t3_rr%0d", i));

    silent = 1'b1;
    key_a[0] = m_ckey; din_a[0] = {$urandom, $urandom};
    txn(2'b01, 1'b0, "t4_timeout");
    silent = 1'b0;
    txn(2'b01, 1'b0, "t4_reload");

    dat_lat = TIMEOUT - 1; txn(2'b01, 1'b0, "t5_data_at_expiry");
    dat_lat = TIMEOUT;     txn(2'b01, 1'b0, "t5_data_late");
    dat_lat = 1;
    key_a[1] = kpool[2]; key_lat = TIMEOUT - 1; txn(2'b10, 1'b0, "t5_key_at_expiry");
    key_a[1] = kpool[1]; key_lat = TIMEOUT;     txn(2'b10, 1'b0, "t5_key_late");
    key_lat = 1;

    silent = 1'b1;
    key_a[0] = kpool[0]; din_a[0] = {$urandom, $urandom};
    v[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (req0_ready) v[0] = 1'b0;
      if (core_din_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_rst.din_en_seen", 128'(seen), 128'(1));
    step();
    rst = 1'b0;
    #1;
    check_zero("t5_rst_mid");
    v = 2'b00;
    step();
    rst = 1'b1;
    rsp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp0_valid || rsp1_valid) rsp_cnt++;
    end
    chk("t5_rst.no_rsp", 128'(rsp_cnt), 128'(0));
    m_last = 1'b1; m_cached = 1'b0; silent = 1'b0;
    txn(2'b01, 1'b0, "t5_after_rst");

    for (int n = 0; n < 24; n++) begin
      v = 2'b00;
      for (int i = 0; i < 2; i++) begin
        key_a[i]  = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom, $urandom, $urandom}
                                                : kpool[$urandom_range(0, 2)];
        din_a[i]  = {$urandom, $urandom};
        flag_a[i] = 1'($urandom_range(0, 1));
      end
      key_lat = $urandom_range(1, 4);
      dat_lat = $urandom_range(1, 4);
      txn(2'($urandom_range(1, 3)), 1'b0, $sformatf("rnd%0d", n));
    end
    v = 2'b00;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
